// File: rtl/torus_pkg.sv
// torus_pkg: shared types, default widths and the dimension-ordered route decode for the torus switch
package torus_pkg;

    localparam int COORD_W_DEF   = 3;
    localparam int PAYLOAD_W_DEF = 32;

    typedef enum logic [1:0] {PORT_N, PORT_W, PORT_PI} in_port_e;
    typedef enum logic [1:0] {OUT_E, OUT_S, OUT_PO} out_port_e;

    // X is resolved first, then Y; a packet already at its coordinates is ejected
    function automatic out_port_e route(input logic [7:0] dst_x, input logic [7:0] dst_y,
                                        input logic [7:0] my_x, input logic [7:0] my_y);
        return (dst_x != my_x) ? OUT_E : (dst_y != my_y) ? OUT_S : OUT_PO;
    endfunction

endpackage

// File: rtl/torus_rr_arb.sv
// torus_rr_arb: N-way round-robin arbiter, one-hot grant gated by output-free enable
module torus_rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;

    // search starts at the pointer; the first requester found wins and sets the next pointer
    always_comb begin
        gnt = '0;
        nxt = ptr;
        for (int i = 0; i < N; i++) begin
            if (en && gnt == '0 && req[PW'((int'(ptr) + i) % N)]) begin
                gnt[PW'((int'(ptr) + i) % N)] = 1'b1;
                nxt = PW'((int'(ptr) + i + 1) % N);
            end
        end
    end

    // pointer only moves when something is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (|gnt)
            ptr <= nxt;
    end

endmodule

// File: rtl/torus_xbar_sw.sv
// torus_xbar_sw: registered 3x3 torus node switch (N/W/PI in, E/S/PO out); optional stall counters under TORUS_XBAR_STATS_EN
module torus_xbar_sw
    import torus_pkg::*;
#(
    parameter  int COORD_W   = COORD_W_DEF,
    parameter  int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter  int MY_X      = 0,
    parameter  int MY_Y      = 0,
    localparam int PKT_W     = 2 * COORD_W + PAYLOAD_W
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TORUS_XBAR_STATS_EN
    input  logic             stats_clr,
    output logic [15:0]      stall_e,
    output logic [15:0]      stall_s,
    output logic [15:0]      stall_po,
`endif
    input  logic             n_valid,
    input  logic [PKT_W-1:0] n_data,
    output logic             n_ready,
    input  logic             w_valid,
    input  logic [PKT_W-1:0] w_data,
    output logic             w_ready,
    input  logic             pi_valid,
    input  logic [PKT_W-1:0] pi_data,
    output logic             pi_ready,
    output logic             s_valid,
    output logic [PKT_W-1:0] s_data,
    input  logic             s_ready,
    output logic             e_valid,
    output logic [PKT_W-1:0] e_data,
    input  logic             e_ready,
    output logic             po_valid,
    output logic [PKT_W-1:0] po_data,
    input  logic             po_ready
);

    logic             in_valid [3];
    logic [PKT_W-1:0] in_data  [3];
    out_port_e        dst      [3];
    logic             o_valid  [3];
    logic [PKT_W-1:0] o_data   [3];
    logic             o_ready  [3];
    logic [2:0]       req      [3];
    logic [2:0]       gnt      [3];
    logic [PKT_W-1:0] nxt_data [3];

    assign in_valid[PORT_N]  = n_valid;
    assign in_valid[PORT_W]  = w_valid;
    assign in_valid[PORT_PI] = pi_valid;
    assign in_data[PORT_N]   = n_data;
    assign in_data[PORT_W]   = w_data;
    assign in_data[PORT_PI]  = pi_data;
    assign o_ready[OUT_E]    = e_ready;
    assign o_ready[OUT_S]    = s_ready;
    assign o_ready[OUT_PO]   = po_ready;

    assign e_valid  = o_valid[OUT_E];
    assign e_data   = o_data[OUT_E];
    assign s_valid  = o_valid[OUT_S];
    assign s_data   = o_data[OUT_S];
    assign po_valid = o_valid[OUT_PO];
    assign po_data  = o_data[OUT_PO];

    assign n_ready  = gnt[OUT_E][PORT_N]  | gnt[OUT_S][PORT_N]  | gnt[OUT_PO][PORT_N];
    assign w_ready  = gnt[OUT_E][PORT_W]  | gnt[OUT_S][PORT_W]  | gnt[OUT_PO][PORT_W];
    assign pi_ready = gnt[OUT_E][PORT_PI] | gnt[OUT_S][PORT_PI] | gnt[OUT_PO][PORT_PI];

    for (genvar i = 0; i < 3; i++) begin : g_route
        assign dst[i] = route(8'(in_data[i][PKT_W-1 -: COORD_W]),
                              8'(in_data[i][PKT_W-COORD_W-1 -: COORD_W]),
                              8'(MY_X), 8'(MY_Y));
    end

    for (genvar o = 0; o < 3; o++) begin : g_out
        for (genvar i = 0; i < 3; i++) begin : g_req
            assign req[o][i] = in_valid[i] && dst[i] == out_port_e'(o);
        end

        torus_rr_arb #(.N(3)) u_arb (
            .clk (clk),
            .rst (rst),
            .req (req[o]),
            .en  (!o_valid[o] || o_ready[o]),
            .gnt (gnt[o])
        );

        assign nxt_data[o] = gnt[o][0] ? in_data[0] : gnt[o][1] ? in_data[1] : in_data[2];

        // a grant always (re)loads the slot; a drain without a grant empties it
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                o_valid[o] <= 1'b0;
                o_data[o]  <= '0;
            end else if (|gnt[o]) begin
                o_valid[o] <= 1'b1;
                o_data[o]  <= nxt_data[o];
            end else if (o_ready[o]) begin
                o_valid[o] <= 1'b0;
            end
        end
    end

`ifdef TORUS_XBAR_STATS_EN
    logic [15:0] stall [3];

    for (genvar o = 0; o < 3; o++) begin : g_stats
        // count cycles where traffic wants this output but none is granted; clear wins
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                stall[o] <= '0;
            else if (stats_clr)
                stall[o] <= '0;
            else if (|req[o] && !(|gnt[o]) && stall[o] != 16'hFFFF)
                stall[o] <= stall[o] + 16'd1;
        end
    end

    assign stall_e  = stall[OUT_E];
    assign stall_s  = stall[OUT_S];
    assign stall_po = stall[OUT_PO];
`endif

endmodule

// File: tb/tb_torus_xbar_sw.sv
// tb_torus_xbar_sw: directed bench for torus_xbar_sw at node (1,2); stall-counter checks under TORUS_XBAR_STATS_EN
module tb_torus_xbar_sw;

    localparam int PKT_W = 38;

    logic clk, rst;
    logic n_valid, w_valid, pi_valid;
    logic [PKT_W-1:0] n_data, w_data, pi_data;
    logic n_ready, w_ready, pi_ready;
    logic e_valid, s_valid, po_valid;
    logic [PKT_W-1:0] e_data, s_data, po_data;
    logic e_ready, s_ready, po_ready;
`ifdef TORUS_XBAR_STATS_EN
    logic stats_clr;
    logic [15:0] stall_e, stall_s, stall_po;
`endif

    int total  = 0;
    int passed = 0;

    torus_xbar_sw #(.COORD_W(3), .PAYLOAD_W(32), .MY_X(1), .MY_Y(2)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef TORUS_XBAR_STATS_EN
        .stats_clr(stats_clr),
        .stall_e  (stall_e),
        .stall_s  (stall_s),
        .stall_po (stall_po),
`endif
        .n_valid  (n_valid),
        .n_data   (n_data),
        .n_ready  (n_ready),
        .w_valid  (w_valid),
        .w_data   (w_data),
        .w_ready  (w_ready),
        .pi_valid (pi_valid),
        .pi_data  (pi_data),
        .pi_ready (pi_ready),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .e_valid  (e_valid),
        .e_data   (e_data),
        .e_ready  (e_ready),
        .po_valid (po_valid),
        .po_data  (po_data),
        .po_ready (po_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] mk(input int x, input int y, input int p);
        return {3'(x), 3'(y), 32'(p)};
    endfunction

    task automatic idle();
        n_valid = 0; w_valid = 0; pi_valid = 0;
        n_data = '0; w_data = '0; pi_data = '0;
        e_ready = 1; s_ready = 1; po_ready = 1;
`ifdef TORUS_XBAR_STATS_EN
        stats_clr = 0;
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        repeat (2) @(negedge clk);
        total++;
        if ({e_valid, s_valid, po_valid} !== 3'b000)
            $display("FAIL reset_valid got %b want 000", {e_valid, s_valid, po_valid});
        else passed++;
        total++;
        if ({e_data, s_data, po_data} !== '0)
            $display("FAIL reset_data got %h want 0", {e_data, s_data, po_data});
        else passed++;
`ifdef TORUS_XBAR_STATS_EN
        total++;
        if ({stall_e, stall_s, stall_po} !== 48'h0)
            $display("FAIL reset_stats got %h want 0", {stall_e, stall_s, stall_po});
        else passed++;
`endif
        rst = 0;
    endtask

    task automatic test_parallel();
        apply_reset();
        @(negedge clk);
        w_valid = 1;  w_data  = mk(3, 0, 32'hA);
        n_valid = 1;  n_data  = mk(1, 5, 32'hB);
        pi_valid = 1; pi_data = mk(1, 2, 32'hC);
        #1;
        total++;
        if ({pi_ready, w_ready, n_ready} !== 3'b111)
            $display("FAIL par_ready got %b want 111", {pi_ready, w_ready, n_ready});
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({e_valid, s_valid, po_valid} !== 3'b111)
            $display("FAIL par_valid got %b want 111", {e_valid, s_valid, po_valid});
        else passed++;
        total++;
        if (e_data !== mk(3, 0, 32'hA)) $display("FAIL par_e got %h want %h", e_data, mk(3, 0, 32'hA));
        else passed++;
        total++;
        if (s_data !== mk(1, 5, 32'hB)) $display("FAIL par_s got %h want %h", s_data, mk(1, 5, 32'hB));
        else passed++;
        total++;
        if (po_data !== mk(1, 2, 32'hC)) $display("FAIL par_po got %h want %h", po_data, mk(1, 2, 32'hC));
        else passed++;
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        total++;
        if ({e_valid, s_valid, po_valid} !== 3'b000)
            $display("FAIL par_drain got %b want 000", {e_valid, s_valid, po_valid});
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [PKT_W-1:0] exp_pkt [3];
        exp_pkt[0] = mk(1, 5, 32'h100);
        exp_pkt[1] = mk(1, 6, 32'h200);
        exp_pkt[2] = mk(1, 0, 32'h300);
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_valid = 1;  n_data  = exp_pkt[0];
            w_valid = 1;  w_data  = exp_pkt[1];
            pi_valid = 1; pi_data = exp_pkt[2];
            #1;
            total++;
            if ({pi_ready, w_ready, n_ready} !== 3'(1 << (k % 3)))
                $display("FAIL rr_ready[%0d] got %b want %b", k, {pi_ready, w_ready, n_ready}, 3'(1 << (k % 3)));
            else passed++;
            @(posedge clk); #1;
            total++;
            if (!s_valid || s_data !== exp_pkt[k % 3])
                $display("FAIL rr_s[%0d] got %b/%h want 1/%h", k, s_valid, s_data, exp_pkt[k % 3]);
            else passed++;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        w_valid = 1; w_data = mk(3, 0, 100);
        @(posedge clk); #1;
        total++;
        if (!e_valid || e_data !== mk(3, 0, 100)) $display("FAIL bp_load got %b/%h", e_valid, e_data);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e_ready = 0; w_data = mk(3, 0, 101);
            #1;
            total++;
            if (w_ready !== 1'b0) $display("FAIL bp_wready[%0d] got %b want 0", k, w_ready);
            else passed++;
            @(posedge clk); #1;
            total++;
            if (!e_valid || e_data !== mk(3, 0, 100))
                $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", k, e_valid, e_data, mk(3, 0, 100));
            else passed++;
        end
`ifdef TORUS_XBAR_STATS_EN
        total++;
        if (stall_e !== 16'd4) $display("FAIL bp_stall_e got %0d want 4", stall_e);
        else passed++;
`endif
        @(negedge clk);
        e_ready = 1;
        #1;
        total++;
        if (w_ready !== 1'b1) $display("FAIL bp_release got %b want 1", w_ready);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (!e_valid || e_data !== mk(3, 0, 101)) $display("FAIL bp_reload got %b/%h want 1/%h", e_valid, e_data, mk(3, 0, 101));
        else passed++;
        @(negedge clk);
        w_data = mk(3, 0, 102);
        @(posedge clk); #1;
        total++;
        if (!e_valid || e_data !== mk(3, 0, 102)) $display("FAIL bp_stream got %b/%h want 1/%h", e_valid, e_data, mk(3, 0, 102));
        else passed++;
`ifdef TORUS_XBAR_STATS_EN
        total++;
        if ({stall_e, stall_s, stall_po} !== {16'd4, 16'd0, 16'd0})
            $display("FAIL bp_stats got %h want 000400000000", {stall_e, stall_s, stall_po});
        else passed++;
`endif
        @(negedge clk);
        idle();
    endtask

    task automatic test_pointer();
        apply_reset();
        @(negedge clk);
        n_valid = 1; n_data = mk(4, 0, 1);
        @(posedge clk); #1;
        total++;
        if (e_data !== mk(4, 0, 1)) $display("FAIL ptr_n got %h want %h", e_data, mk(4, 0, 1));
        else passed++;
        @(negedge clk);
        n_valid = 0;
        pi_valid = 1; pi_data = mk(5, 0, 2);
        #1;
        total++;
        if (pi_ready !== 1'b1) $display("FAIL ptr_pi_ready got %b want 1", pi_ready);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (e_data !== mk(5, 0, 2)) $display("FAIL ptr_pi got %h want %h", e_data, mk(5, 0, 2));
        else passed++;
        @(negedge clk);
        pi_valid = 0;
        n_valid = 1; n_data = mk(4, 0, 3);
        w_valid = 1; w_data = mk(6, 0, 4);
        #1;
        total++;
        if ({w_ready, n_ready} !== 2'b01) $display("FAIL ptr_wrap got %b want 01", {w_ready, n_ready});
        else passed++;
        @(posedge clk); #1;
        total++;
        if (e_data !== mk(4, 0, 3)) $display("FAIL ptr_wrap_e got %h want %h", e_data, mk(4, 0, 3));
        else passed++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        @(negedge clk);
        e_ready = 0; s_ready = 0; po_ready = 0;
        w_valid = 1;  w_data  = mk(3, 0, 7);
        n_valid = 1;  n_data  = mk(1, 5, 8);
        pi_valid = 1; pi_data = mk(1, 2, 9);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({e_valid, s_valid, po_valid} !== 3'b111)
            $display("FAIL mid_loaded got %b want 111", {e_valid, s_valid, po_valid});
        else passed++;
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        total++;
        if ({e_valid, s_valid, po_valid} !== 3'b000)
            $display("FAIL mid_reset_valid got %b want 000", {e_valid, s_valid, po_valid});
        else passed++;
        total++;
        if ({e_data, s_data, po_data} !== '0)
            $display("FAIL mid_reset_data got %h want 0", {e_data, s_data, po_data});
        else passed++;
`ifdef TORUS_XBAR_STATS_EN
        total++;
        if ({stall_e, stall_s, stall_po} !== 48'h0)
            $display("FAIL mid_reset_stats got %h want 0", {stall_e, stall_s, stall_po});
        else passed++;
`endif
        @(negedge clk);
        idle();
        rst = 0;
    endtask

`ifdef TORUS_XBAR_STATS_EN
    task automatic test_stats();
        apply_reset();
        @(negedge clk);
        e_ready = 0;
        w_valid = 1; w_data = mk(3, 0, 55);
        @(posedge clk);
        repeat (70000) @(posedge clk);
        #1;
        total++;
        if (stall_e !== 16'hFFFF) $display("FAIL stats_sat got %h want ffff", stall_e);
        else passed++;
        @(negedge clk);
        stats_clr = 1;
        @(posedge clk); #1;
        total++;
        if (stall_e !== 16'h0) $display("FAIL stats_clr got %h want 0", stall_e);
        else passed++;
        @(negedge clk);
        stats_clr = 0;
        @(posedge clk); #1;
        total++;
        if (stall_e !== 16'h1) $display("FAIL stats_resume got %h want 1", stall_e);
        else passed++;
        @(negedge clk);
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_parallel();
        test_round_robin();
        test_backpressure();
        test_pointer();
        test_mid_reset();
`ifdef TORUS_XBAR_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
